// File: rtl/decode_stage.sv
// Pipelined instruction decode stage: decodes a 32-bit instruction into execute
// controls behind a valid/ready handshake, with a one-entry skid buffer behind the output register.
module decode_stage #(
  parameter int unsigned XLEN           = 64,
  parameter bit          ENABLE_IMM_ALU = 1'b0,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             alu_src_mux,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             branch_ctrl,
  output logic [2:0]       alu_op,
  output logic             reg_src_mux,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  pc_out,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_SD   = 7'b0100011;
  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_BEQ  = 7'b1100011;
  localparam logic [6:0] OPC_IALU = 7'b0010011;

  localparam logic [2:0] ALU_ADD = 3'b111;
  localparam logic [2:0] ALU_SUB = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            branch;
    logic [2:0]      alu_op;
    logic            reg_src;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } payload_t;

  payload_t         dec_c;
  payload_t         out_q, out_d;
  payload_t         skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;
  logic             advance_c;

  logic [6:0]      opcode_c;
  logic [2:0]      funct3_c;
  logic [6:0]      funct7_c;
  logic [XLEN-1:0] imm_i_c;
  logic [XLEN-1:0] imm_s_c;
  logic [XLEN-1:0] imm_b_c;

  assign opcode_c = instr_in[6:0];
  assign funct3_c = instr_in[14:12];
  assign funct7_c = instr_in[31:25];

  assign imm_i_c = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
  assign imm_s_c = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b_c = {{(XLEN-13){instr_in[31]}}, instr_in[31], instr_in[7],
                    instr_in[30:25], instr_in[11:8], 1'b0};

  // Instruction decode; anything not matched falls through as illegal.
  always_comb begin
    dec_c         = '0;
    dec_c.alu_op  = ALU_AND;
    dec_c.reg_src = 1'b1;
    dec_c.illegal = 1'b1;
    dec_c.rs1     = instr_in[19:15];
    dec_c.rs2     = instr_in[24:20];
    dec_c.rd      = instr_in[11:7];
    dec_c.pc      = pc_in;
    case (opcode_c)
      OPC_LD: if (funct3_c == 3'b011) begin
        dec_c.illegal   = 1'b0;
        dec_c.alu_src   = 1'b1;
        dec_c.mem_read  = 1'b1;
        dec_c.alu_op    = ALU_ADD;
        dec_c.reg_write = 1'b1;
        dec_c.reg_src   = 1'b0;
        dec_c.imm       = imm_i_c;
      end
      OPC_SD: if (funct3_c == 3'b011) begin
        dec_c.illegal   = 1'b0;
        dec_c.alu_src   = 1'b1;
        dec_c.mem_write = 1'b1;
        dec_c.alu_op    = ALU_ADD;
        dec_c.imm       = imm_s_c;
      end
      OPC_R: begin
        dec_c.illegal   = 1'b0;
        dec_c.reg_write = 1'b1;
        if (funct3_c == 3'b000 && funct7_c == F7_BASE)      dec_c.alu_op = ALU_ADD;
        else if (funct3_c == 3'b000 && funct7_c == F7_SUB)  dec_c.alu_op = ALU_SUB;
        else if (funct3_c == 3'b111 && funct7_c == F7_BASE) dec_c.alu_op = ALU_AND;
        else if (funct3_c == 3'b110 && funct7_c == F7_BASE) dec_c.alu_op = ALU_OR;
        else begin
          dec_c.illegal   = 1'b1;
          dec_c.reg_write = 1'b0;
        end
      end
      OPC_BEQ: if (funct3_c == 3'b000) begin
        dec_c.illegal = 1'b0;
        dec_c.alu_op  = ALU_SUB;
        dec_c.branch  = 1'b1;
        dec_c.reg_src = 1'b0;
        dec_c.imm     = imm_b_c;
      end
      OPC_IALU: if (ENABLE_IMM_ALU && (funct3_c == 3'b000 || funct3_c == 3'b111 ||
                                       funct3_c == 3'b110)) begin
        dec_c.illegal   = 1'b0;
        dec_c.alu_src   = 1'b1;
        dec_c.reg_write = 1'b1;
        dec_c.imm       = imm_i_c;
        case (funct3_c)
          3'b000:  dec_c.alu_op = ALU_ADD;
          3'b111:  dec_c.alu_op = ALU_AND;
          default: dec_c.alu_op = ALU_OR;
        endcase
      end
      default: ;
    endcase
  end

  // The skid entry is only ever filled while the output holds; it always drains first.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    accept_c     = in_valid && !skid_valid_q;
    advance_c    = !out_valid_q || out_ready;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (advance_c) begin
        if (skid_valid_q) begin
          out_d        = skid_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else begin
          out_valid_d = accept_c;
          if (accept_c) out_d = dec_c;
        end
      end else if (accept_c) begin
        skid_d       = dec_c;
        skid_valid_d = 1'b1;
      end
      if (accept_c && dec_c.illegal && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q         <= '0;
      out_q.alu_op  <= ALU_AND;
      out_q.reg_src <= 1'b1;
      skid_q        <= '0;
      out_valid_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
      cnt_q         <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready      = !skid_valid_q;
  assign out_valid     = out_valid_q;
  assign alu_src_mux   = out_q.alu_src;
  assign mem_read      = out_q.mem_read;
  assign mem_write     = out_q.mem_write;
  assign reg_write     = out_q.reg_write;
  assign branch_ctrl   = out_q.branch;
  assign alu_op        = out_q.alu_op;
  assign reg_src_mux   = out_q.reg_src;
  assign rs1           = out_q.rs1;
  assign rs2           = out_q.rs2;
  assign rd            = out_q.rd;
  assign imm           = out_q.imm;
  assign pc_out        = out_q.pc;
  assign illegal       = out_q.illegal;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (immediate ALU off/on) share stimulus and are
// compared every cycle against a queue-based occupancy model and a mnemonic-level decoder.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, flush;
  logic [31:0] instr_in;
  logic [63:0] pc_in;

  logic        in_ready0, out_valid0, asrc0, mr0, mw0, rw0, br0, rsrc0, ill0;
  logic [2:0]  op0;
  logic [4:0]  rs1_0, rs2_0, rd0;
  logic [63:0] imm0, pc0;
  logic [1:0]  cnt0;
  logic        in_ready1, out_valid1, asrc1, mr1, mw1, rw1, br1, rsrc1, ill1;
  logic [2:0]  op1;
  logic [4:0]  rs1_1, rs2_1, rd1;
  logic [63:0] imm1, pc1;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64), .ENABLE_IMM_ALU(1'b0), .CNT_W(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .instr_in(instr_in),
    .pc_in(pc_in), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .alu_src_mux(asrc0), .mem_read(mr0), .mem_write(mw0), .reg_write(rw0),
    .branch_ctrl(br0), .alu_op(op0), .reg_src_mux(rsrc0), .rs1(rs1_0), .rs2(rs2_0),
    .rd(rd0), .imm(imm0), .pc_out(pc0), .illegal(ill0), .illegal_count(cnt0));

  decode_stage #(.XLEN(64), .ENABLE_IMM_ALU(1'b1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .instr_in(instr_in),
    .pc_in(pc_in), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .alu_src_mux(asrc1), .mem_read(mr1), .mem_write(mw1), .reg_write(rw1),
    .branch_ctrl(br1), .alu_op(op1), .reg_src_mux(rsrc1), .rs1(rs1_1), .rs2(rs2_1),
    .rd(rd1), .imm(imm1), .pc_out(pc1), .illegal(ill1), .illegal_count(cnt1));

  wire [24:0] ctl0 = {asrc0, mr0, mw0, rw0, br0, op0, rsrc0, ill0, rs1_0, rs2_0, rd0};
  wire [24:0] ctl1 = {asrc1, mr1, mw1, rw1, br1, op1, rsrc1, ill1, rs1_1, rs2_1, rd1};

  typedef struct packed {
    bit asrc, mr, mw, rw, br;
    bit [2:0] op;
    bit rsrc, ill;
    bit [63:0] imm;
  } dec_t;

  typedef struct packed {
    bit [31:0] ins;
    bit [63:0] pc;
  } ent_t;

  int   n_total = 0;
  int   n_bad   = 0;
  ent_t q[$];
  int   mcnt0, mcnt1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decoder written per mnemonic, independent of the RTL structure.
  function automatic dec_t ref_dec(input bit [31:0] ins, input bit en);
    dec_t      d;
    bit [6:0]  opc = ins[6:0];
    bit [2:0]  f3  = ins[14:12];
    bit [6:0]  f7  = ins[31:25];
    bit [11:0] ii  = ins[31:20];
    bit [11:0] si  = {ins[31:25], ins[11:7]};
    bit [12:0] bi  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    int        alu = -1;
    d = '0; d.op = 3'b001; d.rsrc = 1'b1; d.ill = 1'b1;
    if (opc == 7'h03 && f3 == 3'd3) begin
      d = '0; d.asrc = 1; d.mr = 1; d.op = 3'b111; d.rw = 1;
      d.imm = longint'($signed(ii));
    end else if (opc == 7'h23 && f3 == 3'd3) begin
      d = '0; d.asrc = 1; d.mw = 1; d.op = 3'b111; d.rsrc = 1;
      d.imm = longint'($signed(si));
    end else if (opc == 7'h63 && f3 == 3'd0) begin
      d = '0; d.op = 3'b000; d.br = 1;
      d.imm = longint'($signed(bi));
    end else if (opc == 7'h33) begin
      if (f7 == 7'h00 && f3 == 3'd0) alu = 7;
      else if (f7 == 7'h20 && f3 == 3'd0) alu = 0;
      else if (f7 == 7'h00 && f3 == 3'd7) alu = 1;
      else if (f7 == 7'h00 && f3 == 3'd6) alu = 3;
      if (alu >= 0) begin
        d = '0; d.rw = 1; d.rsrc = 1; d.op = alu[2:0];
      end
    end else if (opc == 7'h13 && en) begin
      if (f3 == 3'd0) alu = 7;
      else if (f3 == 3'd7) alu = 1;
      else if (f3 == 3'd6) alu = 3;
      if (alu >= 0) begin
        d = '0; d.asrc = 1; d.rw = 1; d.rsrc = 1; d.op = alu[2:0];
        d.imm = longint'($signed(ii));
      end
    end
    return d;
  endfunction

  function automatic logic [24:0] ctl_of(input dec_t d, input bit [31:0] ins);
    return {d.asrc, d.mr, d.mw, d.rw, d.br, d.op, d.rsrc, d.ill,
            ins[19:15], ins[24:20], ins[11:7]};
  endfunction

  function automatic bit [31:0] gen_instr();
    bit [31:0] r = $urandom;
    case ($urandom_range(0, 7))
      0: begin r[6:0] = 7'h03; r[14:12] = 3'd3; end
      1: begin r[6:0] = 7'h23; r[14:12] = 3'd3; end
      2: begin
        r[6:0] = 7'h33;
        case ($urandom_range(0, 4))
          0: begin r[14:12] = 3'd0; r[31:25] = 7'h00; end
          1: begin r[14:12] = 3'd0; r[31:25] = 7'h20; end
          2: begin r[14:12] = 3'd7; r[31:25] = 7'h00; end
          3: begin r[14:12] = 3'd6; r[31:25] = 7'h00; end
          default: ;
        endcase
      end
      3: begin r[6:0] = 7'h63; r[14:12] = 3'd0; end
      4: r[6:0] = 7'h13;
      default: ;
    endcase
    return r;
  endfunction

  // Check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    dec_t e0, e1;
    bit   rdy, ov;
    @(negedge clk);
    if (!rst) begin
      check("in_ready0", 64'(in_ready0), 64'(q.size() < 2));
      check("in_ready1", 64'(in_ready1), 64'(q.size() < 2));
      check("out_valid0", 64'(out_valid0), 64'(q.size() > 0));
      check("out_valid1", 64'(out_valid1), 64'(q.size() > 0));
      check("count0", 64'(cnt0), 64'(mcnt0));
      check("count1", 64'(cnt1), 64'(mcnt1));
      if (q.size() > 0) begin
        e0 = ref_dec(q[0].ins, 1'b0);
        e1 = ref_dec(q[0].ins, 1'b1);
        check("ctl0", 64'(ctl0), 64'(ctl_of(e0, q[0].ins)));
        check("ctl1", 64'(ctl1), 64'(ctl_of(e1, q[0].ins)));
        check("imm0", imm0, e0.imm);
        check("imm1", imm1, e1.imm);
        check("pc0", pc0, q[0].pc);
        check("pc1", pc1, q[0].pc);
      end
    end
    @(posedge clk);
    if (rst) begin
      q.delete(); mcnt0 = 0; mcnt1 = 0;
    end else begin
      rdy = q.size() < 2;
      ov  = q.size() > 0;
      if (flush) q.delete();
      else begin
        if (ov && out_ready) void'(q.pop_front());
        if (in_valid && rdy) begin
          q.push_back('{ins: instr_in, pc: pc_in});
          if (ref_dec(instr_in, 1'b0).ill && mcnt0 < 3) mcnt0++;
          if (ref_dec(instr_in, 1'b1).ill && mcnt1 < 3) mcnt1++;
        end
      end
    end
    #1;
  endtask

  initial begin
    rst = 1; in_valid = 0; out_ready = 0; flush = 0; instr_in = '0; pc_in = '0;
    mcnt0 = 0; mcnt1 = 0;
    cycle(); cycle();
    rst = 0;

    check("rst_out_valid", 64'(out_valid0), 64'(0));
    check("rst_in_ready", 64'(in_ready0), 64'(1));
    check("rst_ctl", 64'(ctl0), 64'({5'b0, 3'b001, 1'b1, 1'b0, 15'b0}));
    check("rst_imm", imm0, 64'd0);
    check("rst_count", 64'(cnt1), 64'(0));

    // ld x5,8(x2)
    in_valid = 1; out_ready = 1; instr_in = 32'h0081_3283; pc_in = 64'h1000;
    cycle();
    in_valid = 0;
    check("ld_valid", 64'(out_valid0), 64'(1));
    check("ld_flags", 64'({mr0, rw0, asrc0, rsrc0, op0}), 64'({4'b1110, 3'b111}));
    check("ld_regs", 64'({rs1_0, rd0}), 64'({5'd2, 5'd5}));
    check("ld_imm", imm0, 64'd8);

    // sub x3,x1,x2 then beq x1,x2,-4 back to back
    in_valid = 1; instr_in = 32'h4020_81B3; pc_in = 64'h1004;
    cycle();
    check("sub_flags", 64'({op0, rw0, rd0}), 64'({3'b000, 1'b1, 5'd3}));
    instr_in = 32'hFE20_8EE3; pc_in = 64'h1008;
    cycle();
    in_valid = 0;
    check("beq_flags", 64'({op0, br0}), 64'({3'b000, 1'b1}));
    check("beq_imm", imm0, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle();

    // Backpressure: three offered, two held
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      instr_in = 32'h0020_80B3 | (32'(i + 1) << 7);
      pc_in = 64'h2000 + 64'(4 * i);
      cycle();
    end
    check("bp_in_ready", 64'(in_ready0), 64'(0));
    check("bp_hold_rd", 64'(rd0), 64'(1));
    in_valid = 0; out_ready = 1;
    cycle(); cycle();
    check("bp_drained", 64'({in_ready0, out_valid0}), 64'(2'b10));

    // Flush with both entries full and input offered
    out_ready = 0; in_valid = 1; instr_in = 32'h0020_80B3; pc_in = 64'h3000;
    cycle(); cycle();
    instr_in = 32'hFFFF_FFFF; flush = 1;
    cycle();
    flush = 0; in_valid = 0;
    check("flush_state", 64'({out_valid0, in_ready0}), 64'(2'b01));
    out_ready = 1;
    cycle(); cycle();

    // Illegal handling and saturation
    in_valid = 1; instr_in = 32'h00A0_8093; pc_in = 64'h4000;
    cycle();
    check("addi_off", 64'({ill0, rw0, op0}), 64'({2'b10, 3'b001}));
    check("addi_on", 64'({ill1, op1, asrc1}), 64'({1'b0, 3'b111, 1'b1}));
    check("addi_imm", imm1, 64'd10);
    instr_in = 32'hFFFF_FFFF;
    repeat (5) cycle();
    in_valid = 0;
    cycle();
    check("sat_count0", 64'(cnt0), 64'(3));
    check("sat_count1", 64'(cnt1), 64'(3));

    // Reset mid-operation
    out_ready = 0; in_valid = 1; instr_in = 32'h0020_80B3;
    cycle(); cycle();
    rst = 1;
    cycle();
    rst = 0; in_valid = 0;
    check("midrst", 64'({out_valid0, in_ready0, cnt0}), 64'(4'b0100));

    // Random valid/ready/flush traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 4);
      instr_in  = gen_instr();
      pc_in     = {$urandom, $urandom};
      cycle();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined successor to the combinational control decoder. It takes a full 32-bit instruction and PC from fetch over a valid/ready handshake.
- It produces registered control signals, register indices and a sign-extended immediate for execute, with one cycle of latency.
- A 2-entry skid buffer provides full throughput under backpressure. The block also adds flush, illegal-instruction flagging with a saturating counter, and an optional immediate-ALU mode.

Parameters:
- XLEN, 64, datapath width for pc and imm.
- ENABLE_IMM_ALU, 0, 1 decodes opcode 0010011 (ADDI/ANDI/ORI); 0 treats it as illegal.
- CNT_W, 8, width of illegal_count.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instr_in/pc_in valid.
- in_ready  out  1  stage can accept; transfer when in_valid&&in_ready.
- instr_in  in  32  instruction.
- pc_in  in  XLEN  instruction PC.
- flush  in  1  discard all held and incoming instructions.
- out_valid  out  1  decoded outputs valid.
- out_ready  in  1  execute accepts; transfer when out_valid&&out_ready.
- alu_src_mux  out  1  0=REG, 1=IMM.
- mem_read, mem_write, reg_write, branch_ctrl  out  1 each.
- alu_op  out  3  ADD=111, SUB=000, AND=001, OR=011.
- reg_src_mux  out  1  0=MEM, 1=ALU.
- rs1, rs2, rd  out  5 each  instr[19:15], [24:20], [11:7].
- imm  out  XLEN  sign-extended immediate.
- pc_out  out  XLEN  PC of the decoded instruction.
- illegal  out  1  decoded instruction unsupported.
- illegal_count  out  CNT_W  accepted illegal instructions, saturating.

Behaviour:
- Reset, synchronous: out_valid=0, in_ready=1, skid empty, illegal_count=0. All payload outputs are 0, with alu_op=AND(001) and reg_src_mux=ALU.
- Decode table (opcode / funct3 / funct7):
  - LD: 0000011 / 011. Outputs IMM, mem_read=1, ADD, reg_write=1, MEM.
  - SD: 0100011 / 011. Outputs IMM, mem_write=1, ADD, ALU.
  - R-type: 0110011.
    - ADD: 000 / 0000000.
    - SUB: 000 / 0100000.
    - AND: 111 / 0000000.
    - OR: 110 / 0000000.
    - All four output REG, reg_write=1, ALU, with alu_op per instruction.
  - BEQ: 1100011 / 000. Outputs REG, SUB, branch_ctrl=1.
  - I-ALU (ENABLE_IMM_ALU=1 only): 0010011. funct3 000 gives ADD, 111 gives AND, 110 gives OR. Outputs IMM, reg_write=1, ALU.
  - Anything else is illegal. Illegal outputs: REG, mem_read/mem_write/reg_write/branch_ctrl all 0, AND, ALU, illegal=1. An illegal instruction still flows through the stage; it is never dropped.
- Immediate generation, sign bit instr[31]:
  - I-format (LD, I-ALU): instr[31:20].
  - S-format: {instr[31:25], instr[11:7]}.
  - B-format: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - R-type and illegal: 0.
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1 if the output register is empty or being drained.
- Buffering: output register plus one skid entry.
  - in_ready is registered: in_ready = !skid_full.
  - If the output holds an unaccepted entry and a new instruction is accepted, the new instruction goes to skid.
  - When the output is consumed, skid moves to the output in the same edge.
- Payload stability: outputs must be stable while out_valid=1 and out_ready=0.
- Ordering: strictly in order; no loss, no duplication.
- Simultaneous input accept and output drain with skid empty: the new entry loads the output register directly. Sustained throughput is 1 per cycle.
- Flush, highest priority: on the next edge out_valid=0, skid is emptied and in_ready=1. An input handshake in the flush cycle is dropped and not counted. An out handshake in the flush cycle still counts as consumed.
- illegal_count:
  - Increments by 1 on each accepted illegal instruction (non-flush cycle).
  - Holds at 2^CNT_W-1 when saturated.
  - Unaffected by flush; cleared only by rst.
- Reset asserted mid-operation discards everything and applies reset values on that edge.

Test Plan:
- Reset, then in_valid=1 with instr_in=0x00813283 (ld x5,8(x2)) and out_ready=1 → next cycle:
  - out_valid=1, mem_read=1, reg_write=1, alu_src_mux=IMM, reg_src_mux=MEM, alu_op=111.
  - rs1=2, rd=5, imm=8.
- Back-to-back 0x402081B3 (sub x3,x1,x2) then 0xFE208EE3 (beq x1,x2,-4) → consecutive cycles show:
  - SUB: alu_op=000, reg_write=1, rd=3.
  - BEQ: alu_op=000, branch_ctrl=1, imm=-4 (all ones except [1:0]=00).
- Backpressure: out_ready=0 while 3 instructions are offered → 2 accepted and in_ready falls to 0. Outputs hold the first instruction unchanged. Releasing out_ready drains both in order, then in_ready=1.
- Flush with both entries full plus an input handshake in the same cycle → next cycle out_valid=0, in_ready=1. No entry emerges afterward and illegal_count is unchanged.
- Illegal handling with CNT_W=2:
  - ENABLE_IMM_ALU=0: 0x00A08093 (addi x1,x1,10) → illegal=1, reg_write=0, alu_op=001.
  - Send 5 illegal instructions → illegal_count reaches 3 and stays there.
  - ENABLE_IMM_ALU=1: same addi → illegal=0, alu_op=111, alu_src_mux=IMM, imm=10.
- Random valid/ready/flush stimulus checked against a reference queue → in-order delivery, no loss or duplication across flushes, and stable payload under stall.
